router_pkt_tx: RTL and testbench

Packet transmitter that drives the write side of the 4-deep router packet FIFO. It frames a burst of 8-bit payload bytes into 10-bit packets: one header, then data beats, with the last beat marked as tail. It presents each packet on `packet` with a one-cycle `fifo_wr_en` strobe. A credit counter sized to the downstream FIFO depth prevents overrun; the consumer returns one credit per entry drained.

---
 rtl/router_pkt_tx_if.sv | 32 +++
 rtl/router_pkt_tx.sv | 132 +++++++++++++
 tb/tb_router_pkt_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if -- bundles every non-clock/reset signal of the packet
// transmitter into one interface.
//   slave  : transmitter view (burst request, payload stream and credit
//            return in; packet/strobe, status and credits out)
//   master : driver/consumer view, the mirror image of slave
interface router_pkt_tx_if #(
  parameter int CREDIT_W = 3
);
  logic                tx_start;
  logic [1:0]          tx_dest;
  logic [3:0]          tx_len;
  logic                tx_busy;
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                credit_return;
  logic [9:0]          packet;
  logic                fifo_wr_en;
  logic [CREDIT_W-1:0] credits;
  logic                tx_done;
  logic                credit_err;

  modport master (
    output tx_start, tx_dest, tx_len, in_valid, in_data, credit_return,
    input  tx_busy, in_ready, packet, fifo_wr_en, credits, tx_done, credit_err
  );

  modport slave (
    input  tx_start, tx_dest, tx_len, in_valid, in_data, credit_return,
    output tx_busy, in_ready, packet, fifo_wr_en, credits, tx_done, credit_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx -- frames a burst of payload bytes into 10-bit packets
// (header, data beats, tail) and writes them into the downstream router FIFO,
// one fifo_wr_en strobe per packet, gated by a credit counter.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : router_pkt_tx_if.slave
//           tx_start/tx_dest/tx_len  burst request (sampled in IDLE only)
//           tx_busy                  FSM not in IDLE
//           in_valid/in_data/in_ready payload byte handshake
//           credit_return            one FIFO entry drained downstream
//           packet/fifo_wr_en        registered FIFO write
//           credits                  free downstream entries
//           tx_done                  pulse with the tail write
//           credit_err               sticky credit overflow flag
// Packet type in packet[9:8]: 10 header, 01 data, 11 tail data.
module router_pkt_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDIT_W   = 3
) (
  input logic             clk,
  input logic             n_rst,
  router_pkt_tx_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] CREDITS_FULL = CREDIT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t              state;
  logic [1:0]          dest_q;
  logic [3:0]          len_q;
  logic [3:0]          beat_cnt;
  logic [CREDIT_W-1:0] credits_q;
  logic [9:0]          packet_q;
  logic                wr_q;
  logic                done_q;
  logic                err_q;

  logic has_credit;
  logic in_ready_c;
  logic emit_hdr;
  logic emit_data;
  logic emit;

  // Emission is gated by the registered credit count only, so a credit
  // returned in the same cycle cannot enable a write.
  // NOTE: every signal assigned in always_comb gets a value on every path;
  // the plain full assignments here cannot infer a latch.
  always_comb begin
    has_credit = (credits_q != '0);
    in_ready_c = (state == DATA) && has_credit;
    emit_hdr   = (state == HDR) && has_credit;
    emit_data  = in_ready_c && bus.in_valid;
    emit       = emit_hdr || emit_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      credits_q <= CREDITS_FULL;
      packet_q  <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_q   <= emit;
      done_q <= 1'b0;

      // Emission and return in the same cycle cancel out.
      case ({emit, bus.credit_return})
        2'b10: credits_q <= credits_q - 1'b1;
        2'b01: begin
          if (credits_q == CREDITS_FULL) begin
            err_q <= 1'b1;
          end else begin
            credits_q <= credits_q + 1'b1;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (bus.tx_start) begin
            dest_q   <= bus.tx_dest;
            len_q    <= bus.tx_len;
            beat_cnt <= '0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (emit_hdr) begin
            packet_q <= {2'b10, 2'b00, dest_q, len_q};
            state    <= DATA;
          end
        end
        DATA: begin
          if (emit_data) begin
            if (beat_cnt == len_q) begin
              packet_q <= {2'b11, bus.in_data};
              done_q   <= 1'b1;
              state    <= IDLE;
            end else begin
              packet_q <= {2'b01, bus.in_data};
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_busy    = (state != IDLE);
  assign bus.in_ready   = in_ready_c;
  assign bus.packet     = packet_q;
  assign bus.fifo_wr_en = wr_q;
  assign bus.credits    = credits_q;
  assign bus.tx_done    = done_q;
  assign bus.credit_err = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx -- self-checking bench for router_pkt_tx: directed
// scenarios followed by randomized bursts checked against a packet-list and
// FIFO-occupancy reference model.
module tb_router_pkt_tx;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  router_pkt_tx_if #(.CREDIT_W(3)) bus();

  router_pkt_tx #(.FIFO_DEPTH(DEPTH), .CREDIT_W(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tx_start      = 1'b0;
    bus.tx_dest       = '0;
    bus.tx_len        = '0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.credit_return = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
  endtask

  // Returns credits until the counter is full again (bounded).
  task automatic restore_credits();
    int guard = 0;
    while (bus.credits != 3'(DEPTH) && guard < 20) begin
      bus.credit_return = 1'b1;
      tick();
      guard++;
    end
    bus.credit_return = 1'b0;
    n_checks++;
    if (bus.credits !== 3'(DEPTH)) begin
      n_fail++; $display("FAIL restore_credits got=%0d exp=%0d", bus.credits, DEPTH);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 1'b0;
    tick();
    n_checks += 7;
    if (bus.packet !== 10'h000) begin n_fail++; $display("FAIL rst_packet got=%h exp=000", bus.packet); end
    if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%b exp=0", bus.fifo_wr_en); end
    if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_tx_done got=%b exp=0", bus.tx_done); end
    if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL rst_credit_err got=%b exp=0", bus.credit_err); end
    if (bus.credits !== 3'd4) begin n_fail++; $display("FAIL rst_credits got=%0d exp=4", bus.credits); end
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.tx_busy); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    bus.tx_start = 1'b1; bus.tx_dest = 2'b01; bus.tx_len = 4'd0;
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    tick();
    bus.tx_start = 1'b0;
    n_checks += 2;
    if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL sb_no_wr_yet got=%b exp=0", bus.fifo_wr_en); end
    if (bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy got=%b exp=1", bus.tx_busy); end
    tick();
    n_checks += 4;
    if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL sb_hdr_wr got=%b exp=1", bus.fifo_wr_en); end
    if (bus.packet !== 10'h210) begin n_fail++; $display("FAIL sb_hdr_pkt got=%h exp=210", bus.packet); end
    if (bus.credits !== 3'd3) begin n_fail++; $display("FAIL sb_credits3 got=%0d exp=3", bus.credits); end
    if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL sb_done_early got=%b exp=0", bus.tx_done); end
    tick();
    n_checks += 5;
    if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL sb_tail_wr got=%b exp=1", bus.fifo_wr_en); end
    if (bus.packet !== 10'h3A5) begin n_fail++; $display("FAIL sb_tail_pkt got=%h exp=3a5", bus.packet); end
    if (bus.tx_done !== 1'b1) begin n_fail++; $display("FAIL sb_done got=%b exp=1", bus.tx_done); end
    if (bus.credits !== 3'd2) begin n_fail++; $display("FAIL sb_credits2 got=%0d exp=2", bus.credits); end
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL sb_idle got=%b exp=0", bus.tx_busy); end
    bus.in_valid = 1'b0;
    tick();
    n_checks += 3;
    if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL sb_wr_drop got=%b exp=0", bus.fifo_wr_en); end
    if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL sb_done_drop got=%b exp=0", bus.tx_done); end
    if (bus.packet !== 10'h3A5) begin n_fail++; $display("FAIL sb_pkt_hold got=%h exp=3a5", bus.packet); end
  endtask

  task automatic test_credit_stall_resume();
    logic [7:0] b[5];
    logic [9:0] e;
    int idx = 0;
    int writes = 0;
    int dones = 0;
    int guard = 0;
    exp_q.delete();
    exp_q.push_back(10'h204);
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      exp_q.push_back({(i == 4) ? 2'b11 : 2'b01, b[i]});
    end
    bus.tx_start = 1'b1; bus.tx_dest = 2'b00; bus.tx_len = 4'd4;
    bus.in_valid = 1'b1; bus.in_data = b[0];
    tick();
    bus.tx_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.fifo_wr_en) begin
        writes++;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.packet !== e) begin n_fail++; $display("FAIL stall_pkt got=%h exp=%h", bus.packet, e); end
        if (e[9:8] != 2'b10) begin idx++; if (idx < 5) bus.in_data = b[idx]; end
      end
    end
    n_checks += 4;
    if (writes != 4) begin n_fail++; $display("FAIL stall_writes got=%0d exp=4", writes); end
    if (bus.credits !== 3'd0) begin n_fail++; $display("FAIL stall_credits got=%0d exp=0", bus.credits); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    if (bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got=%b exp=1", bus.tx_busy); end
    // A credit returned at zero cannot enable emission in the same cycle.
    bus.credit_return = 1'b1;
    tick();
    n_checks += 2;
    if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_ret_wr got=%b exp=0", bus.fifo_wr_en); end
    if (bus.credits !== 3'd1) begin n_fail++; $display("FAIL zero_ret_credits got=%0d exp=1", bus.credits); end
    while (exp_q.size() != 0 && guard < 10) begin
      tick();
      guard++;
      if (bus.tx_done) dones++;
      if (bus.fifo_wr_en) begin
        e = exp_q.pop_front();
        n_checks += 3;
        if (bus.packet !== e) begin n_fail++; $display("FAIL resume_pkt got=%h exp=%h", bus.packet, e); end
        if (bus.tx_done !== (e[9:8] == 2'b11)) begin n_fail++; $display("FAIL resume_done got=%b exp=%b", bus.tx_done, e[9:8] == 2'b11); end
        if (bus.credits !== 3'd1) begin n_fail++; $display("FAIL resume_credits got=%0d exp=1", bus.credits); end
        idx++; if (idx < 5) bus.in_data = b[idx];
      end
    end
    bus.credit_return = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    n_checks += 3;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL resume_left got=%0d exp=0", exp_q.size()); end
    if (dones != 1) begin n_fail++; $display("FAIL resume_dones got=%0d exp=1", dones); end
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL resume_idle got=%b exp=0", bus.tx_busy); end
    restore_credits();
  endtask

  task automatic test_simultaneous();
    // Bring credits to 2 with a single-beat burst first.
    bus.tx_start = 1'b1; bus.tx_dest = 2'b10; bus.tx_len = 4'd0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick();
    bus.tx_start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.credits !== 3'd2) begin n_fail++; $display("FAIL sim_pre_credits got=%0d exp=2", bus.credits); end
    bus.tx_start = 1'b1; bus.tx_dest = 2'b11; bus.tx_len = 4'd0; bus.in_data = 8'h3C;
    tick();
    bus.tx_start = 1'b0;
    bus.credit_return = 1'b1;
    tick();
    bus.credit_return = 1'b0;
    n_checks += 3;
    if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL sim_wr got=%b exp=1", bus.fifo_wr_en); end
    if (bus.packet !== 10'h230) begin n_fail++; $display("FAIL sim_hdr got=%h exp=230", bus.packet); end
    if (bus.credits !== 3'd2) begin n_fail++; $display("FAIL sim_credits got=%0d exp=2", bus.credits); end
    tick();
    bus.in_valid = 1'b0;
    n_checks += 2;
    if (bus.packet !== 10'h33C) begin n_fail++; $display("FAIL sim_tail got=%h exp=33c", bus.packet); end
    if (bus.credits !== 3'd1) begin n_fail++; $display("FAIL sim_credits1 got=%0d exp=1", bus.credits); end
    tick();
    restore_credits();
  endtask

  task automatic test_overflow();
    bus.credit_return = 1'b1;
    tick();
    bus.credit_return = 1'b0;
    n_checks += 2;
    if (bus.credits !== 3'd4) begin n_fail++; $display("FAIL ovf_credits got=%0d exp=4", bus.credits); end
    if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", bus.credit_err); end
    repeat (3) tick();
    n_checks++;
    if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus.credit_err); end
    do_reset();
    n_checks++;
    if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", bus.credit_err); end
  endtask

  task automatic test_ignore_and_reset();
    logic [7:0] b[3];
    logic [9:0] e;
    int writes = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      exp_q.push_back({(i == 2) ? 2'b11 : 2'b01, b[i]});
    end
    bus.tx_start = 1'b1; bus.tx_dest = 2'b10; bus.tx_len = 4'd2;
    tick();
    bus.tx_start = 1'b0;
    tick();
    n_checks++;
    if (bus.packet !== 10'h222) begin n_fail++; $display("FAIL ign_hdr got=%h exp=222", bus.packet); end
    // Start request while in DATA must not disturb the latched length.
    bus.tx_start = 1'b1; bus.tx_len = 4'd15; bus.tx_dest = 2'b01;
    tick();
    bus.tx_start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = b[0];
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.fifo_wr_en) begin
        writes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL ign_extra_write got=%h exp=none", bus.packet);
        end else begin
          e = exp_q.pop_front();
          if (bus.packet !== e) begin n_fail++; $display("FAIL ign_pkt got=%h exp=%h", bus.packet, e); end
          if (writes < 3) bus.in_data = b[writes];
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks += 2;
    if (writes != 3) begin n_fail++; $display("FAIL ign_writes got=%0d exp=3", writes); end
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle got=%b exp=0", bus.tx_busy); end
    restore_credits();
    // Asynchronous reset in the middle of a burst.
    bus.tx_start = 1'b1; bus.tx_dest = 2'b01; bus.tx_len = 4'd5;
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    tick();
    bus.tx_start = 1'b0;
    repeat (2) tick();
    #2;
    n_rst = 1'b0;
    #1;
    n_checks += 4;
    if (bus.packet !== 10'h000) begin n_fail++; $display("FAIL arst_packet got=%h exp=000", bus.packet); end
    if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL arst_wr got=%b exp=0", bus.fifo_wr_en); end
    if (bus.credits !== 3'd4) begin n_fail++; $display("FAIL arst_credits got=%0d exp=4", bus.credits); end
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%b exp=0", bus.tx_busy); end
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  // Randomized back-to-back bursts against a packet-list / occupancy model:
  // credits must always equal DEPTH minus the entries sitting in the FIFO.
  task automatic test_random();
    logic [7:0] b[16];
    logic [9:0] e;
    logic [3:0] len;
    logic [1:0] dest;
    int occ = 0;
    int idx;
    int guard;
    logic ret, acc;
    for (int burst = 0; burst < 25; burst++) begin
      dest = 2'($urandom);
      len  = 4'($urandom_range(0, 15));
      exp_q.delete();
      exp_q.push_back({2'b10, 2'b00, dest, len});
      for (int i = 0; i <= int'(len); i++) begin
        b[i] = 8'($urandom);
        exp_q.push_back({(i == int'(len)) ? 2'b11 : 2'b01, b[i]});
      end
      idx = 0;
      guard = 0;
      bus.tx_start = 1'b1; bus.tx_dest = dest; bus.tx_len = len;
      while (exp_q.size() != 0 && guard < 400) begin
        bus.in_valid = (idx <= int'(len)) && ($urandom_range(0, 3) != 0);
        bus.in_data  = (idx <= int'(len)) ? b[idx] : 8'h00;
        ret = (occ > 0) && ($urandom_range(0, 1) == 1);
        bus.credit_return = ret;
        acc = bus.in_valid && bus.in_ready;
        if (bus.in_ready && bus.credits == 3'd0) begin
          n_checks++; n_fail++; $display("FAIL rnd_ready_no_credit got=1 exp=0");
        end
        tick();
        if (guard == 0) begin
          n_checks++;
          if (bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL rnd_start burst=%0d got=%b exp=1", burst, bus.tx_busy); end
        end
        bus.tx_start = 1'b0;
        guard++;
        if (acc) idx++;
        if (ret) occ--;
        if (bus.fifo_wr_en) begin
          occ++;
          e = exp_q.pop_front();
          n_checks += 2;
          if (bus.packet !== e) begin n_fail++; $display("FAIL rnd_pkt burst=%0d got=%h exp=%h", burst, bus.packet, e); end
          if (bus.tx_done !== (e[9:8] == 2'b11)) begin n_fail++; $display("FAIL rnd_done burst=%0d got=%b exp=%b", burst, bus.tx_done, e[9:8] == 2'b11); end
        end
        n_checks++;
        if (bus.credits !== 3'(DEPTH - occ)) begin
          n_fail++; $display("FAIL rnd_credits burst=%0d got=%0d exp=%0d", burst, bus.credits, DEPTH - occ);
        end
      end
      n_checks += 2;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_timeout burst=%0d left=%0d exp=0", burst, exp_q.size()); end
      if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle burst=%0d got=%b exp=0", burst, bus.tx_busy); end
    end
    bus.in_valid = 1'b0;
    while (occ > 0) begin
      bus.credit_return = 1'b1;
      tick();
      occ--;
    end
    bus.credit_return = 1'b0;
    n_checks += 2;
    if (bus.credits !== 3'd4) begin n_fail++; $display("FAIL rnd_final_credits got=%0d exp=4", bus.credits); end
    if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL rnd_credit_err got=%b exp=0", bus.credit_err); end
  endtask

  initial begin
    idle_inputs();
    n_rst = 1'b0;
    test_reset();
    test_single_beat();
    restore_credits();
    test_credit_stall_resume();
    test_simultaneous();
    test_overflow();
    test_ignore_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
